// File: rtl/lzx_traffic_ctrl.sv
// lzx_traffic_ctrl: sequencer for one traffic signal head.
// Cycles RED -> GREEN -> YELLOW -> RED with programmable phase lengths counted in
// en ticks. A pedestrian request may cut GREEN short once MIN_G ticks have passed.
// A lamp fault reported by the downstream checker forces a sticky all-stop LOCK
// that only rst clears.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   en         timing tick enable
//   ped_req    pedestrian request (level or pulse)
//   fault_in   lamp fault flag from lzx_trafficlights
//   R, Y, G    registered lamp drives, exactly one high
//   state      00 RED, 01 GREEN, 10 YELLOW, 11 LOCK
//   remain     ticks left in the current phase minus 1
//   ped_ack    one-cycle pulse in the first RED cycle after a serviced request
//   fault_lock sticky fault indicator
module lzx_traffic_ctrl #(
    parameter int unsigned R_TIME = 16,
    parameter int unsigned G_TIME = 20,
    parameter int unsigned Y_TIME = 4,
    parameter int unsigned MIN_G  = 5,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ped_req,
    input  logic             fault_in,
    output logic             R,
    output logic             Y,
    output logic             G,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] remain,
    output logic             ped_ack,
    output logic             fault_lock
);

    typedef enum logic [1:0] {
        StRed    = 2'b00,
        StGreen  = 2'b01,
        StYellow = 2'b10,
        StLock   = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] RLoad = CNT_W'(R_TIME - 1);
    localparam logic [CNT_W-1:0] GLoad = CNT_W'(G_TIME - 1);
    localparam logic [CNT_W-1:0] YLoad = CNT_W'(Y_TIME - 1);
    // remain at or below this value means at least MIN_G GREEN ticks have elapsed
    // once the current tick is counted.
    localparam logic [CNT_W-1:0] GExit = CNT_W'(G_TIME - MIN_G);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remain_q, remain_d;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             r_q, r_d, y_q, y_d, g_q, g_d;
    logic             lock_q, lock_d;
    logic             ped_eff;

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        pend_d   = pend_q;
        ack_d    = 1'b0;
        // A request arriving this cycle counts as pending for this cycle's decision.
        ped_eff  = pend_q | ped_req;

        if (fault_in || state_q == StLock) begin
            state_d  = StLock;
            remain_d = '0;
            pend_d   = 1'b0;
        end else begin
            pend_d = ped_eff;
            if (en) begin
                case (state_q)
                    StRed: begin
                        if (remain_q == '0) begin
                            state_d  = StGreen;
                            remain_d = GLoad;
                        end else begin
                            remain_d = remain_q - CNT_W'(1);
                        end
                    end
                    StGreen: begin
                        if (remain_q == '0 || (ped_eff && remain_q <= GExit)) begin
                            state_d  = StYellow;
                            remain_d = YLoad;
                        end else begin
                            remain_d = remain_q - CNT_W'(1);
                        end
                    end
                    StYellow: begin
                        if (remain_q == '0) begin
                            state_d  = StRed;
                            remain_d = RLoad;
                            ack_d    = ped_eff;
                            // A request on the clearing edge survives into the next cycle.
                            pend_d   = ped_req;
                        end else begin
                            remain_d = remain_q - CNT_W'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Lamps decoded from the next state so they register alongside it.
        r_d    = (state_d == StRed) || (state_d == StLock);
        g_d    = (state_d == StGreen);
        y_d    = (state_d == StYellow);
        lock_d = (state_d == StLock);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StRed;
            remain_q <= RLoad;
            pend_q   <= 1'b0;
            ack_q    <= 1'b0;
            r_q      <= 1'b1;
            y_q      <= 1'b0;
            g_q      <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            pend_q   <= pend_d;
            ack_q    <= ack_d;
            r_q      <= r_d;
            y_q      <= y_d;
            g_q      <= g_d;
            lock_q   <= lock_d;
        end
    end

    assign R          = r_q;
    assign Y          = y_q;
    assign G          = g_q;
    assign state      = state_q;
    assign remain     = remain_q;
    assign ped_ack    = ack_q;
    assign fault_lock = lock_q;

endmodule

// File: doc/lzx_traffic_ctrl.md
Name: lzx_traffic_ctrl

Overview:
- Sequencer for one traffic signal head, sitting directly upstream of lzx_trafficlights.
- Drives the R/Y/G lamp lines that lzx_trafficlights checks, and consumes that checker's Z output as a fault input.
- Normal cycle is RED → GREEN → YELLOW → RED, with programmable durations and a pedestrian request that shortens GREEN.
- Any reported lamp fault forces a sticky all-stop lock that only reset clears.

Parameters:
- R_TIME, 16: RED duration in ticks (≥1).
- G_TIME, 20: GREEN duration in ticks (≥1).
- Y_TIME, 4: YELLOW duration in ticks (≥1).
- MIN_G, 5: minimum GREEN ticks before a pedestrian request may end GREEN (1..G_TIME).
- CNT_W, 8: counter width; every *_TIME-1 must fit.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  timing tick enable; counting advances only on cycles with en=1.
- ped_req  in  1  pedestrian request, level or pulse, sampled every cycle.
- fault_in  in  1  lamp fault flag (Z of lzx_trafficlights).
- R  out  1  red lamp, registered.
- Y  out  1  yellow lamp, registered.
- G  out  1  green lamp, registered.
- state  out  2  00 RED, 01 GREEN, 10 YELLOW, 11 LOCK.
- remain  out  CNT_W  ticks left in current phase minus 1.
- ped_ack  out  1  one-cycle pulse when a pending request is serviced.
- fault_lock  out  1  sticky fault indicator.

Behaviour:
- One clock domain. Reset is synchronous and active-high: clk and rst.
- Reset values:
  - state=RED, R=1, Y=0, G=0.
  - remain=R_TIME-1.
  - ped_pending=0, ped_ack=0, fault_lock=0.
- Lamp outputs are decoded registered from state and are one-hot in every cycle:
  - RED and LOCK: R only.
  - GREEN: G only.
  - YELLOW: Y only.
  - No combinational path exists from fault_in to R/Y/G, so there is no loop through the checker.
- Priority per edge: rst > fault > timing.
- Fault handling:
  - fault_in=1 on any cycle (en ignored) moves state to LOCK on the next cycle.
  - In LOCK: R=1, fault_lock=1, remain=0, ped_pending cleared, ped_req ignored, ped_ack=0.
  - Only rst exits LOCK.
- Timing, on an en=1 cycle outside LOCK:
  - If remain==0: advance to the next state and load its duration-1 (RED→GREEN load G_TIME-1; GREEN→YELLOW load Y_TIME-1; YELLOW→RED load R_TIME-1).
  - Otherwise: remain decrements.
  - On an en=0 cycle: state and remain hold.
- Phase length: each phase lasts exactly its *_TIME en-ticks.
- Pedestrian early exit:
  - Condition: en=1, state=GREEN, ped_pending=1, and remain ≤ G_TIME-MIN_G.
  - Action: advance to YELLOW immediately and load Y_TIME-1.
  - Effect: GREEN lasts max(MIN_G, ticks until the request) ticks, never fewer than MIN_G.
- ped_pending:
  - Set by ped_req in any state except LOCK.
  - Cleared on the YELLOW→RED transition.
  - ped_ack is high in the first RED cycle if ped_pending was set at the transition.
  - If ped_req is high in the same cycle as the clear, set wins: pending stays 1 for the next GREEN, and ped_ack still pulses.
- Reset mid-operation: any state, including LOCK, returns to the reset values on the next edge.
- No arithmetic wrap: remain is never decremented below 0.

Test Plan:
- rst 2 cycles, then en=1, no ped/fault → R high for cycles 1-16, G for 17-36, Y for 37-40, R again at 41. R+Y+G==1 every cycle; remain 15→0, then 19 at the first G cycle.
- en asserted 1 cycle in 4 → RED lasts 64 clocks, GREEN 80, YELLOW 16. remain and state are unchanged on en=0 cycles.
- 1-cycle ped_req in the 2nd GREEN tick → Y rises after exactly 5 GREEN ticks. ped_ack pulses once, in the first R cycle after YELLOW. Next GREEN is full 20 ticks. ped_req held after MIN_G has elapsed (GREEN tick 12) → Y on the following tick.
- ped_req high exactly on the YELLOW→RED edge → ped_ack=1 and ped_pending stays set. Next GREEN ends after 5 ticks.
- fault_in 1-cycle pulse in GREEN tick 7 → next cycle R=1, G=0, state=11, fault_lock=1. Holds for 200 cycles despite ped_req and en toggling; rst restores R=1, remain=15, fault_lock=0.
- rst in YELLOW tick 2 with ped_pending=1 → next cycle state=RED, remain=15, ped_pending=0. No ped_ack on the following YELLOW→RED transition unless new ped_req.
